// File: rtl/alu_lanes_seq.sv
// alu_lanes_seq: L-lane, N-bit sequential ALU with valid/ready handshakes.
//
// Sel (shared by all lanes):
//   0 zero, 1 pass A, 2 A+B, 3 A-B, 4 A*B (low N bits, unsigned),
//   5 A/B (unsigned, N-cycle restoring divide), 6/7 see ALU_LANES_SAT_EN.
// Every operation except divide produces its result on the accepting edge.
// Divide runs one quotient bit per cycle on every lane in parallel and shares
// a single iteration counter.
//
// Optional feature, macro ALU_LANES_SAT_EN:
//   defined   -> Sel 6 signed saturating A+B, Sel 7 signed saturating A-B
//   undefined -> Sel 6/7 give result 0 (flags {0,1,0,0}); no saturation logic
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted this cycle (IDLE, or HOLD with out_ready)
//   A, B       lane operands, lane i at [i*N+N-1 : i*N]
//   Sel        operation select
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   C          lane results, same packing as A
//   Flags      per-lane {N,Z,V,C}, lane i at [4i+3 : 4i]
module alu_lanes_seq #(
    parameter int N = 32,
    parameter int L = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [L*N-1:0] A,
    input  logic [L*N-1:0] B,
    input  logic [2:0]     Sel,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [L*N-1:0] C,
    output logic [4*L-1:0] Flags
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           vld_p1;
    logic [L*N-1:0] c_p1;
    logic [4*L-1:0] flags_p1;

    // divider working registers (datapath only, never reset)
    logic [L*N-1:0] quo_q;
    logic [L*N-1:0] rem_q;
    logic [L*N-1:0] dvs_q;

    logic [L*N-1:0] imm_c;
    logic [4*L-1:0] imm_f;
    logic [L*N-1:0] quo_nx;
    logic [L*N-1:0] rem_nx;
    logic [4*L-1:0] div_f;

    logic accept;
    logic start_div;
    logic start_imm;

`ifdef ALU_LANES_SAT_EN
    localparam logic [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    // Returns {clamped, result}. One extra sign bit exposes overflow.
    function automatic logic [N:0] sat_add(input logic signed [N-1:0] a,
                                           input logic signed [N-1:0] b);
        logic signed [N:0] s;
        logic              ovf;
        s   = {a[N-1], a} + {b[N-1], b};
        ovf = s[N] ^ s[N-1];
        return {ovf, ovf ? (s[N] ? SMIN : SMAX) : s[N-1:0]};
    endfunction

    function automatic logic [N:0] sat_sub(input logic signed [N-1:0] a,
                                           input logic signed [N-1:0] b);
        logic signed [N:0] s;
        logic              ovf;
        s   = {a[N-1], a} - {b[N-1], b};
        ovf = s[N] ^ s[N-1];
        return {ovf, ovf ? (s[N] ? SMIN : SMAX) : s[N-1:0]};
    endfunction
`endif

    // Single-cycle lane operation; returns {N,Z,V,C, result}.
    function automatic logic [N+3:0] alu_lane(input logic [N-1:0] a,
                                              input logic [N-1:0] b,
                                              input logic [2:0]   sel);
        logic [N:0]     sum;
        logic [2*N-1:0] prod;
        logic [N-1:0]   r;
        logic           v;
        logic           cf;
        sum  = '0;
        prod = '0;
        r    = '0;
        v    = 1'b0;
        cf   = 1'b0;
        case (sel)
            3'd1: r = a;
            3'd2: begin
                sum = {1'b0, a} + {1'b0, b};
                r   = sum[N-1:0];
                cf  = sum[N];
                v   = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'd3: begin
                r  = a - b;
                cf = (a >= b);
                v  = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            3'd4: begin
                prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
                r    = prod[N-1:0];
                cf   = |prod[2*N-1:N];
            end
`ifdef ALU_LANES_SAT_EN
            3'd6: {v, r} = sat_add(a, b);
            3'd7: {v, r} = sat_sub(a, b);
`endif
            default: r = '0;
        endcase
        return {r[N-1], (r == '0), v, cf, r};
    endfunction

    assign in_ready  = rst && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign start_div = accept && (Sel == 3'd5);
    assign start_imm = accept && (Sel != 3'd5);

    // ---- stage p0: combinational lane ALU on the incoming operands ----
    always_comb begin
        logic [N+3:0] lane_r;
        lane_r = '0;
        imm_c  = '0;
        imm_f  = '0;
        for (int i = 0; i < L; i++) begin
            lane_r              = alu_lane(A[i*N +: N], B[i*N +: N], Sel);
            imm_c[i*N +: N]     = lane_r[N-1:0];
            imm_f[4*i +: 4]     = lane_r[N+3:N];
        end
    end

    // One restoring-division step per lane. Dividend bits shift out of the
    // top of quo_q while quotient bits shift in at the bottom. A zero divisor
    // always "fits", so the quotient naturally ends up all-ones.
    always_comb begin
        logic [N:0]   rem_sh;
        logic         ge;
        logic [N-1:0] q;
        rem_sh = '0;
        ge     = 1'b0;
        q      = '0;
        quo_nx = '0;
        rem_nx = '0;
        div_f  = '0;
        for (int i = 0; i < L; i++) begin
            rem_sh = {rem_q[i*N +: N], quo_q[i*N+N-1]};
            ge     = (rem_sh >= {1'b0, dvs_q[i*N +: N]});
            rem_nx[i*N +: N] = ge ? (rem_sh[N-1:0] - dvs_q[i*N +: N]) : rem_sh[N-1:0];
            q      = {quo_q[i*N +: N-1], ge};
            quo_nx[i*N +: N] = q;
            div_f[4*i +: 4]  = {q[N-1], (q == '0), 1'b0, (dvs_q[i*N +: N] == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (start_div) begin
            quo_q <= A;
            rem_q <= '0;
            dvs_q <= B;
        end else if (state == DIV) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
        end
    end

    // ---- stage p1: control FSM and registered outputs ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vld_p1   <= 1'b0;
            c_p1     <= '0;
            flags_p1 <= '0;
        end else begin
            case (state)
                DIV: begin
                    if (cnt == CW'(N-1)) begin
                        c_p1     <= quo_nx;
                        flags_p1 <= div_f;
                        vld_p1   <= 1'b1;
                        cnt      <= '0;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE or HOLD: a new request may coincide with the
                    // output transfer in HOLD.
                    if (start_div) begin
                        cnt    <= '0;
                        vld_p1 <= 1'b0;
                        state  <= DIV;
                    end else if (start_imm) begin
                        c_p1     <= imm_c;
                        flags_p1 <= imm_f;
                        vld_p1   <= 1'b1;
                        state    <= HOLD;
                    end else if ((state == HOLD) && out_ready) begin
                        vld_p1 <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign out_valid = vld_p1;
    assign C         = c_p1;
    assign Flags     = flags_p1;

endmodule
